spi_cmd_receiver: RTL and testbench

Parametrised SPI slave front end for the digit-recognizer datapath. Deserialises MOSI into DATA_W-bit words and decodes a leading opcode byte per SS frame. Streams pixel words with an address into the image buffer, or loads a one-hot expected label and requests a cost calculation. Generalises the fixed 8-bit/72-pixel input controller with configurable width, frame length, label count and sampling edge, plus frame-abort and error reporting.

---
 rtl/spi_cmd_receiver_if.sv | 37 +++
 rtl/spi_cmd_receiver.sv | 197 +++++++++++++++++++
 tb/tb_spi_cmd_receiver.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_receiver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_cmd_receiver_if                                                        |
// | SPI pins, command handshake and image-buffer/label bus of spi_cmd_receiver |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface spi_cmd_receiver_if #(
  parameter int DATA_W     = 8,
  parameter int NUM_PIXELS = 784,
  parameter int NUM_LABELS = 10
);
  localparam int ADDR_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  logic                  sck;
  logic                  mosi;
  logic                  ss_n;
  logic                  accept;
  logic [DATA_W-1:0]     pix_data;
  logic [ADDR_W-1:0]     pix_addr;
  logic                  pix_we;
  logic [NUM_LABELS-1:0] label;
  logic                  calc_cost;
  logic                  frame_done;
  logic                  abort;
  logic                  err;

  modport slave (
    input  sck, mosi, ss_n, accept,
    output pix_data, pix_addr, pix_we, label, calc_cost, frame_done, abort, err
  );

  modport master (
    output sck, mosi, ss_n, accept,
    input  pix_data, pix_addr, pix_we, label, calc_cost, frame_done, abort, err
  );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_cmd_receiver                                                           |
// | SPI slave: opcode-decoded pixel streaming and one-hot label loading.       |
// | Option macro: SPI_RX_LABEL_CHECK_EN (reject out-of-range label values).    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module spi_cmd_receiver #(
  parameter int DATA_W      = 8,
  parameter int NUM_PIXELS  = 784,
  parameter int NUM_LABELS  = 10,
  parameter int SAMPLE_EDGE = 0
) (
  input  wire logic           clk,
  input  wire logic           n_rst,
  spi_cmd_receiver_if.slave   bus
);
  localparam int ADDR_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int BIT_W  = $clog2(DATA_W);
  localparam logic [BIT_W-1:0]  C_LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [DATA_W-1:0] C_OP_PIX    = DATA_W'(0);
  localparam logic [DATA_W-1:0] C_OP_LABEL  = DATA_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PIX   = 3'd1,
    LABEL = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                r_state;
  logic [1:0]            r_sck_sync;
  logic [1:0]            r_mosi_sync;
  logic [1:0]            r_ss_sync;
  logic                  r_sck_d;
  logic                  r_ss_d;
  logic [DATA_W-1:0]     r_shift;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [ADDR_W-1:0]     r_pix_cnt;
  logic [DATA_W-1:0]     r_pix_data;
  logic [ADDR_W-1:0]     r_pix_addr;
  logic                  r_pix_we;
  logic [NUM_LABELS-1:0] r_label;
  logic                  r_calc_cost;
  logic                  r_frame_done;
  logic                  r_abort;
  logic                  r_err;

  logic                  w_sck;
  logic                  w_ss_n;
  logic                  w_ss_rise;
  logic                  w_sck_edge;
  logic                  w_sample;
  logic                  w_word_valid;
  logic [DATA_W-1:0]     w_word;
  logic                  w_label_ok;
  logic [NUM_LABELS-1:0] w_onehot;

  assign w_sck        = r_sck_sync[1];
  assign w_ss_n       = r_ss_sync[1];
  assign w_ss_rise    = w_ss_n & ~r_ss_d;
  assign w_sck_edge   = (SAMPLE_EDGE == 0) ? (w_sck & ~r_sck_d) : (~w_sck & r_sck_d);
  assign w_sample     = w_sck_edge & ~w_ss_n;
  assign w_word       = {r_shift[DATA_W-2:0], r_mosi_sync[1]};
  assign w_word_valid = w_sample && (r_bit_cnt == C_LAST_BIT);
  assign w_label_ok   = {{(32-DATA_W){1'b0}}, w_word} < 32'(NUM_LABELS);
  assign w_onehot     = {{(NUM_LABELS-1){1'b0}}, 1'b1} << w_word;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sck_sync  <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_ss_sync   <= 2'b11;
      r_sck_d     <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[0], bus.sck};
      r_mosi_sync <= {r_mosi_sync[0], bus.mosi};
      r_ss_sync   <= {r_ss_sync[0], bus.ss_n};
      r_sck_d     <= w_sck;
      r_ss_d      <= w_ss_n;
    end
  end

  // Deselect flushes any partial word so every frame starts bit-aligned.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_ss_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_sample) begin
      r_shift   <= w_word;
      r_bit_cnt <= (r_bit_cnt == C_LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_pix_cnt    <= '0;
      r_pix_data   <= '0;
      r_pix_addr   <= '0;
      r_pix_we     <= 1'b0;
      r_label      <= '0;
      r_calc_cost  <= 1'b0;
      r_frame_done <= 1'b0;
      r_abort      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_pix_we     <= 1'b0;
      r_calc_cost  <= 1'b0;
      r_frame_done <= 1'b0;
      r_abort      <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_word_valid) begin
            if (!bus.accept) begin
              r_err   <= 1'b1;
              r_state <= DRAIN;
            end else if (w_word == C_OP_PIX) begin
              r_pix_cnt  <= '0;
              r_pix_addr <= '0;
              r_state    <= PIX;
            end else if (w_word == C_OP_LABEL) begin
              r_state <= LABEL;
            end else begin
              r_err   <= 1'b1;
              r_state <= DRAIN;
            end
          end
        end
        // A completing word wins over a simultaneous deselect.
        PIX: begin
          if (w_word_valid) begin
            r_pix_we   <= 1'b1;
            r_pix_data <= w_word;
            r_pix_addr <= r_pix_cnt;
            if (r_pix_cnt == C_LAST_ADDR) begin
              r_state <= DONE;
            end else begin
              r_pix_cnt <= r_pix_cnt + 1'b1;
            end
          end else if (w_ss_rise) begin
            r_abort <= 1'b1;
            r_state <= IDLE;
          end
        end
        LABEL: begin
          if (w_word_valid) begin
            if (w_label_ok) begin
              r_label     <= w_onehot;
              r_calc_cost <= 1'b1;
              r_state     <= DONE;
            end else begin
`ifdef SPI_RX_LABEL_CHECK_EN
              r_err   <= 1'b1;
              r_state <= DRAIN;
`else
              r_label     <= '0;
              r_calc_cost <= 1'b1;
              r_state     <= DONE;
`endif
            end
          end else if (w_ss_rise) begin
            r_abort <= 1'b1;
            r_state <= IDLE;
          end
        end
        DONE: begin
          r_frame_done <= 1'b1;
          r_state      <= DRAIN;
        end
        DRAIN: begin
          if (w_ss_n) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pix_data   = r_pix_data;
  assign bus.pix_addr   = r_pix_addr;
  assign bus.pix_we     = r_pix_we;
  assign bus.label      = r_label;
  assign bus.calc_cost  = r_calc_cost;
  assign bus.frame_done = r_frame_done;
  assign bus.abort      = r_abort;
  assign bus.err        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_cmd_receiver                                                        |
// | Directed bench: pixel, label, abort and error frames (DATA_W=8, 4 pixels). |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_spi_cmd_receiver;
  localparam int HALF = 60;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_fail;
  int   cyc;

  int         we_cnt, cc_cnt, fd_cnt, ab_cnt, er_cnt;
  int         last_we_cyc, last_cc_cyc, last_fd_cyc;
  logic [7:0] we_data [64];
  logic [1:0] we_addr [64];
  logic [9:0] cc_label;
  int         b_we, b_cc, b_fd, b_ab, b_er;

  spi_cmd_receiver_if #(.DATA_W(8), .NUM_PIXELS(4), .NUM_LABELS(10)) bus ();

  spi_cmd_receiver #(
    .DATA_W(8), .NUM_PIXELS(4), .NUM_LABELS(10), .SAMPLE_EDGE(0)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts high cycles, so a stretched pulse shows up as extra counts.
  always @(negedge clk) begin
    if (bus.pix_we) begin
      if (we_cnt < 64) begin
        we_data[we_cnt] = bus.pix_data;
        we_addr[we_cnt] = bus.pix_addr;
      end
      we_cnt      = we_cnt + 1;
      last_we_cyc = cyc;
    end
    if (bus.calc_cost) begin
      cc_cnt      = cc_cnt + 1;
      cc_label    = bus.label;
      last_cc_cyc = cyc;
    end
    if (bus.frame_done) begin
      fd_cnt      = fd_cnt + 1;
      last_fd_cyc = cyc;
    end
    if (bus.abort) ab_cnt = ab_cnt + 1;
    if (bus.err)   er_cnt = er_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.mosi = v[i];
      bus.sck  = 1'b0;
      #(HALF);
      bus.sck  = 1'b1;
      #(HALF);
    end
    bus.sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
  endtask

  task automatic frame_begin();
    bus.ss_n = 1'b0;
    #(HALF);
  endtask

  task automatic frame_end();
    #(HALF);
    bus.ss_n = 1'b1;
    #(HALF + 20);
  endtask

  task automatic snap();
    b_we = we_cnt; b_cc = cc_cnt; b_fd = fd_cnt; b_ab = ab_cnt; b_er = er_cnt;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix_data"},   32'(bus.pix_data),   32'h0);
    check({tag, "_pix_addr"},   32'(bus.pix_addr),   32'h0);
    check({tag, "_pix_we"},     32'(bus.pix_we),     32'h0);
    check({tag, "_label"},      32'(bus.label),      32'h0);
    check({tag, "_calc_cost"},  32'(bus.calc_cost),  32'h0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 32'h0);
    check({tag, "_abort"},      32'(bus.abort),      32'h0);
    check({tag, "_err"},        32'(bus.err),        32'h0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    we_cnt = 0; cc_cnt = 0; fd_cnt = 0; ab_cnt = 0; er_cnt = 0;
    last_we_cyc = 0; last_cc_cyc = 0; last_fd_cyc = 0; cc_label = '0;
    n_rst = 1'b0;
    bus.ss_n = 1'b0; bus.sck = 1'b0; bus.mosi = 1'b1; bus.accept = 1'b1;

    // Reset held while the bus is active
    for (int i = 0; i < 8; i++) begin
      #30 bus.sck = ~bus.sck;
    end
    @(negedge clk);
    check_outputs_zero("in_reset");
    check("in_reset_no_pulses", 32'(we_cnt + cc_cnt + fd_cnt + ab_cnt + er_cnt), 32'd0);
    bus.ss_n = 1'b1;
    bus.sck  = 1'b0;
    #100;
    @(negedge clk);
    n_rst = 1'b1;
    #100;
    @(negedge clk);
    check_outputs_zero("post_reset");

    // Pixel frame
    snap();
    frame_begin();
    send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    frame_end();
    check("pix_we_count", 32'(we_cnt - b_we), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pix_addr_%0d", i), 32'(we_addr[b_we + i]), 32'(i));
      check($sformatf("pix_data_%0d", i), 32'(we_data[b_we + i]), 32'(8'h11 * (i + 1)));
    end
    check("pix_frame_done", 32'(fd_cnt - b_fd), 32'd1);
    check("pix_done_after_last_we", 32'(last_fd_cyc - last_we_cyc), 32'd1);
    check("pix_no_err_abort", 32'((er_cnt - b_er) + (ab_cnt - b_ab)), 32'd0);

    // Label 7
    snap();
    frame_begin();
    send_byte(8'h01); send_byte(8'h07);
    frame_end();
    check("lbl7_label", 32'(bus.label), 32'h080);
    check("lbl7_label_at_cc", 32'(cc_label), 32'h080);
    check("lbl7_calc_cost", 32'(cc_cnt - b_cc), 32'd1);
    check("lbl7_frame_done", 32'(fd_cnt - b_fd), 32'd1);
    check("lbl7_done_after_cc", 32'(last_fd_cyc - last_cc_cyc), 32'd1);
    check("lbl7_err", 32'(er_cnt - b_er), 32'd0);

    // Out-of-range label 12
    snap();
    frame_begin();
    send_byte(8'h01); send_byte(8'h0C);
    frame_end();
`ifdef SPI_RX_LABEL_CHECK_EN
    check("lbl12_label", 32'(bus.label), 32'h080);
    check("lbl12_err", 32'(er_cnt - b_er), 32'd1);
    check("lbl12_calc_cost", 32'(cc_cnt - b_cc), 32'd0);
    check("lbl12_frame_done", 32'(fd_cnt - b_fd), 32'd0);
`else
    check("lbl12_label", 32'(bus.label), 32'h000);
    check("lbl12_err", 32'(er_cnt - b_er), 32'd0);
    check("lbl12_calc_cost", 32'(cc_cnt - b_cc), 32'd1);
    check("lbl12_frame_done", 32'(fd_cnt - b_fd), 32'd1);
`endif

    // Abort after two pixels and three bits
    snap();
    frame_begin();
    send_byte(8'h00); send_byte(8'hA1); send_byte(8'hB2); send_bits(8'hE0, 3);
    frame_end();
    check("abort_we_count", 32'(we_cnt - b_we), 32'd2);
    check("abort_addr0", 32'(we_addr[b_we]), 32'd0);
    check("abort_data0", 32'(we_data[b_we]), 32'hA1);
    check("abort_addr1", 32'(we_addr[b_we + 1]), 32'd1);
    check("abort_data1", 32'(we_data[b_we + 1]), 32'hB2);
    check("abort_pulse", 32'(ab_cnt - b_ab), 32'd1);
    check("abort_no_done", 32'(fd_cnt - b_fd), 32'd0);

    snap();
    frame_begin();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    frame_end();
    check("restart_we_count", 32'(we_cnt - b_we), 32'd4);
    check("restart_addr0", 32'(we_addr[b_we]), 32'd0);
    check("restart_data0", 32'(we_data[b_we]), 32'h01);
    check("restart_addr3", 32'(we_addr[b_we + 3]), 32'd3);
    check("restart_data3", 32'(we_data[b_we + 3]), 32'h04);
    check("restart_frame_done", 32'(fd_cnt - b_fd), 32'd1);

    // Bad opcode
    snap();
    frame_begin();
    send_byte(8'h05); send_byte(8'h10); send_byte(8'h20);
    frame_end();
    check("badop_err", 32'(er_cnt - b_er), 32'd1);
    check("badop_no_we", 32'(we_cnt - b_we), 32'd0);
    check("badop_no_done", 32'(fd_cnt - b_fd), 32'd0);

    // Command rejected by downstream
    snap();
    bus.accept = 1'b0;
    frame_begin();
    send_byte(8'h00); send_byte(8'h55); send_byte(8'h66);
    frame_end();
    bus.accept = 1'b1;
    check("reject_err", 32'(er_cnt - b_er), 32'd1);
    check("reject_no_we", 32'(we_cnt - b_we), 32'd0);
    check("reject_no_abort", 32'(ab_cnt - b_ab), 32'd0);

    // Back in IDLE: a fresh label frame works
    snap();
    frame_begin();
    send_byte(8'h01); send_byte(8'h03);
    frame_end();
    check("recover_label", 32'(bus.label), 32'h008);
    check("recover_calc_cost", 32'(cc_cnt - b_cc), 32'd1);
    check("recover_err", 32'(er_cnt - b_er), 32'd0);

    @(negedge clk);
    check_outputs_zero_pulses();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic check_outputs_zero_pulses();
    check("idle_pix_we", 32'(bus.pix_we), 32'h0);
    check("idle_calc_cost", 32'(bus.calc_cost), 32'h0);
    check("idle_frame_done", 32'(bus.frame_done), 32'h0);
    check("idle_abort", 32'(bus.abort), 32'h0);
    check("idle_err", 32'(bus.err), 32'h0);
  endtask
endmodule
`default_nettype wire
